weight_update_sequencer: RTL and testbench
==========================================

Name: weight_update_sequencer

Overview:
- Owns the single write port of the weight shadow memory in the clk_spsa (1 MHz) domain.
- Arbitrates write bursts between the host bulk loader and the A-SPSA engine, then runs the swap_req/swap_ack handshake that commits the shadow bank to the NN side.
- Aborts in-flight SPSA bursts on a temperature-state change.
- Sits between aspsa_engine, the host loader and shadow_memory.

Parameters:
- DATA_WIDTH, 16, weight word width (Q1.15).
- ADDR_WIDTH, 16, weight address width.
- NUM_WEIGHTS, 1298, words per bank; valid addresses are 0..NUM_WEIGHTS-1.
- SWAP_TIMEOUT, 1024, cycles allowed per swap handshake phase.

Ports:
- clk  in  1  clk_spsa domain clock.
- rst  in  1  reset.
- host_req  in  1  host burst request (level).
- host_gnt  out  1  host owns write port.
- host_addr  in  ADDR_WIDTH  host write address.
- host_data  in  DATA_WIDTH  host write data.
- host_we  in  1  host write strobe.
- host_last  in  1  final beat of host burst, qualified by host_we.
- host_bank  in  2  target bank for host burst.
- spsa_req  in  1  SPSA burst request (level).
- spsa_gnt  out  1  SPSA owns write port.
- spsa_addr  in  ADDR_WIDTH  SPSA write address.
- spsa_data  in  DATA_WIDTH  SPSA write data.
- spsa_we  in  1  SPSA write strobe.
- spsa_last  in  1  final SPSA beat, qualified by spsa_we.
- temp_bank  in  2  current temperature state; is the SPSA target bank.
- temp_changed  in  1  one-cycle pulse on temperature-state change.
- mem_addr  out  ADDR_WIDTH  shadow memory write address.
- mem_data  out  DATA_WIDTH  shadow memory write data.
- mem_we  out  1  shadow memory write enable.
- mem_bank_sel  out  2  shadow memory bank select.
- swap_req  out  1  swap request (4-phase).
- swap_ack  in  1  swap acknowledge.
- busy  out  1  state != IDLE.
- swap_count  out  16  completed swaps, wraps at 0xFFFF->0.
- abort_pulse  out  1  one-cycle pulse when an SPSA burst is aborted.
- err_status  out  3  sticky flags: [0] swap timeout, [1] address out of range, [2] write with no grant.

Behaviour:
- Reset: clk with synchronous active-high rst. All outputs 0; FSM in IDLE; arbitration pointer set to host.
- FSM states: IDLE, HOST_BURST, SPSA_BURST, SWAP_REQ, SWAP_REL.
- IDLE:
  - Evaluates requests each cycle.
  - Fixed priority: host beats SPSA.
  - Grant is registered: req seen at cycle n gives gnt high at n+1.
  - Latches the burst bank at grant: host_bank for host, temp_bank for SPSA.
- Bursts are never preempted by the other requester.
- Write forwarding:
  - Owner's we/addr/data are registered onto mem_* with 1-cycle latency.
  - mem_bank_sel = latched bank.
- Burst end:
  - Owner we&last ends the burst; the last beat is still written.
  - gnt drops the next cycle and the FSM enters SWAP_REQ.
- Requester drop: if the owner drops req before last, the burst ends without swap and the FSM returns to IDLE.
- Address range: a beat with addr >= NUM_WEIGHTS is suppressed (mem_we stays 0) and sets err_status[1]. The burst continues.
- No-grant writes: host_we or spsa_we without the matching gnt sets err_status[2] and is ignored.
- SPSA abort:
  - temp_changed in SPSA_BURST drops spsa_gnt next cycle, pulses abort_pulse, and returns to IDLE with no swap.
  - A beat coincident with temp_changed is suppressed.
  - temp_changed in HOST_BURST or swap states has no effect.
- SWAP_REQ: swap_req=1 until swap_ack=1, then go to SWAP_REL.
- SWAP_REL:
  - swap_req=0; wait for swap_ack=0.
  - On exit, swap_count += 1 and return to IDLE.
- Swap timeout:
  - A per-phase counter resets on state entry.
  - Reaching SWAP_TIMEOUT sets err_status[0], forces swap_req=0 and returns to IDLE; swap_count is not incremented.
- Mid-operation rst: the burst is dropped and swap_req is deasserted the next cycle. No partial-state retention.
- Error clearing: err_status is cleared only by rst.

Optional Feature:
- Macro: WUS_RR_ARB_EN.
- Defined: round-robin arbitration. When both requests are pending in IDLE, grant the requester not served last. The pointer updates at every grant.
- Undefined: fixed host priority as above; the pointer logic is absent.

Decomposition:
- Shared package (dpd_pkg): FSM state encoding localparams, err_status bit indices, owner encoding (NONE/HOST/SPSA).
- One natural sub-module: swap_handshake (SWAP_REQ/SWAP_REL FSM, timeout counter, swap_count), instantiated by weight_update_sequencer.

Test Plan:
- Host burst at addr 0..3, data 0x1000..0x1003, last on addr 3, host_bank=2 -> 4 mem_we pulses, each 1 cycle after host_we, mem_bank_sel=2; swap_req high; ack after 5 cycles -> swap_count=1, busy=0.
- host_req and spsa_req high in the same cycle -> host_gnt first. In WUS_RR_ARB_EN build, a second simultaneous request after the host burst -> spsa_gnt.
- SPSA burst, temp_changed pulse at beat 2 -> beats 0,1 written, beat 2 suppressed, abort_pulse=1 for 1 cycle, swap_req never asserted.
- swap_ack held 0 -> err_status[0]=1 after SWAP_TIMEOUT=1024 cycles, swap_req=0, FSM in IDLE, swap_count unchanged.
- SPSA write addr 1298 -> mem_we stays 0, err_status[1]=1; host_we while spsa owns the port -> err_status[2]=1.
- rst asserted during SWAP_REQ -> next cycle swap_req=0, all outputs 0, swap_count=0.

Source files
------------

// File: rtl/dpd_pkg.sv
// Shared encodings for the weight update sequencer: FSM states, owner codes
// and err_status bit positions.
package dpd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOST_BURST = 3'd1,
        ST_SPSA_BURST = 3'd2,
        ST_SWAP_REQ   = 3'd3,
        ST_SWAP_REL   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_SPSA = 2'd2
    } owner_t;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_ADDR    = 1;
    localparam int ERR_NOGNT   = 2;

endpackage

// File: rtl/weight_update_sequencer_swap_handshake.sv
// Four-phase swap_req/swap_ack handshake with a per-phase timeout and a
// wrapping count of completed swaps.
module swap_handshake #(
    parameter int SWAP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        swap_ack,
    output logic        swap_req,
    output logic [15:0] swap_count,
    output logic        done,
    output logic        timeout
);
    import dpd_pkg::*;

    localparam int CNT_W = $clog2(SWAP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWAP_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             expired;

    // done fires in the same cycle the phase FSM leaves, so the owner FSM
    // can return to idle on the identical edge.
    always_comb begin
        expired = (cnt == CNT_LAST);
        timeout = ((state == ST_SWAP_REQ) && !swap_ack && expired) ||
                  ((state == ST_SWAP_REL) &&  swap_ack && expired);
        done    = ((state == ST_SWAP_REL) && !swap_ack) || timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            swap_req   <= 1'b0;
            cnt        <= '0;
            swap_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SWAP_REQ;
                        swap_req <= 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_SWAP_REQ: begin
                    if (swap_ack) begin
                        state    <= ST_SWAP_REL;
                        swap_req <= 1'b0;
                        cnt      <= '0;
                    end else if (expired) begin
                        state    <= ST_IDLE;
                        swap_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SWAP_REL: begin
                    if (!swap_ack) begin
                        state      <= ST_IDLE;
                        swap_count <= swap_count + 16'd1;
                    end else if (expired) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    swap_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/weight_update_sequencer.sv
// Write-port owner for the weight shadow memory: arbitrates host/SPSA bursts
// and commits the bank via swap_handshake. Define WUS_RR_ARB_EN for round-robin.
module weight_update_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_WEIGHTS  = 1298,
    parameter int SWAP_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_req,
    output logic                  host_gnt,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_we,
    input  logic                  host_last,
    input  logic [1:0]            host_bank,
    input  logic                  spsa_req,
    output logic                  spsa_gnt,
    input  logic [ADDR_WIDTH-1:0] spsa_addr,
    input  logic [DATA_WIDTH-1:0] spsa_data,
    input  logic                  spsa_we,
    input  logic                  spsa_last,
    input  logic [1:0]            temp_bank,
    input  logic                  temp_changed,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic [1:0]            mem_bank_sel,
    output logic                  swap_req,
    input  logic                  swap_ack,
    output logic                  busy,
    output logic [15:0]           swap_count,
    output logic                  abort_pulse,
    output logic [2:0]            err_status
);
    import dpd_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_WEIGHTS);

    state_t                         state;
    owner_t                         pick;
    logic [1:0]                     bank;
    logic                           vld_p1;
    logic [ADDR_WIDTH-1:0]          addr_p1;
    logic signed [DATA_WIDTH-1:0]   data_p1;
    logic                           swap_start;
    logic                           swap_done;
    logic                           swap_timeout;
`ifdef WUS_RR_ARB_EN
    owner_t                         pref;
`endif

    always_comb begin
        pick = OWN_NONE;
`ifdef WUS_RR_ARB_EN
        if (host_req && spsa_req)
            pick = (pref == OWN_SPSA) ? OWN_SPSA : OWN_HOST;
        else if (host_req)
            pick = OWN_HOST;
        else if (spsa_req)
            pick = OWN_SPSA;
`else
        if (host_req)
            pick = OWN_HOST;
        else if (spsa_req)
            pick = OWN_SPSA;
`endif
        swap_start = ((state == ST_HOST_BURST) && host_we && host_last) ||
                     ((state == ST_SPSA_BURST) && spsa_we && spsa_last && !temp_changed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            host_gnt    <= 1'b0;
            spsa_gnt    <= 1'b0;
            bank        <= 2'd0;
            vld_p1      <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
            abort_pulse <= 1'b0;
            err_status  <= 3'd0;
`ifdef WUS_RR_ARB_EN
            pref        <= OWN_HOST;
`endif
        end else begin
            vld_p1      <= 1'b0;
            abort_pulse <= 1'b0;
            if (swap_timeout)
                err_status[ERR_TIMEOUT] <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (host_we || spsa_we)
                        err_status[ERR_NOGNT] <= 1'b1;
                    if (pick == OWN_HOST) begin
                        state    <= ST_HOST_BURST;
                        host_gnt <= 1'b1;
                        bank     <= host_bank;
`ifdef WUS_RR_ARB_EN
                        pref     <= OWN_SPSA;
`endif
                    end else if (pick == OWN_SPSA) begin
                        state    <= ST_SPSA_BURST;
                        spsa_gnt <= 1'b1;
                        bank     <= temp_bank;
`ifdef WUS_RR_ARB_EN
                        pref     <= OWN_HOST;
`endif
                    end
                end
                // Write stage: owner beat is registered onto mem_* one cycle later.
                ST_HOST_BURST: begin
                    if (spsa_we)
                        err_status[ERR_NOGNT] <= 1'b1;
                    if (host_we) begin
                        if (host_addr < ADDR_LIMIT) begin
                            vld_p1  <= 1'b1;
                            addr_p1 <= host_addr;
                            data_p1 <= $signed(host_data);
                        end else begin
                            err_status[ERR_ADDR] <= 1'b1;
                        end
                    end
                    if (host_we && host_last) begin
                        state    <= ST_SWAP_REQ;
                        host_gnt <= 1'b0;
                    end else if (!host_req) begin
                        state    <= ST_IDLE;
                        host_gnt <= 1'b0;
                    end
                end
                ST_SPSA_BURST: begin
                    if (host_we)
                        err_status[ERR_NOGNT] <= 1'b1;
                    if (temp_changed) begin
                        state       <= ST_IDLE;
                        spsa_gnt    <= 1'b0;
                        abort_pulse <= 1'b1;
                    end else begin
                        if (spsa_we) begin
                            if (spsa_addr < ADDR_LIMIT) begin
                                vld_p1  <= 1'b1;
                                addr_p1 <= spsa_addr;
                                data_p1 <= $signed(spsa_data);
                            end else begin
                                err_status[ERR_ADDR] <= 1'b1;
                            end
                        end
                        if (spsa_we && spsa_last) begin
                            state    <= ST_SWAP_REQ;
                            spsa_gnt <= 1'b0;
                        end else if (!spsa_req) begin
                            state    <= ST_IDLE;
                            spsa_gnt <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (host_we || spsa_we)
                        err_status[ERR_NOGNT] <= 1'b1;
                    if (swap_done)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    swap_handshake #(
        .SWAP_TIMEOUT (SWAP_TIMEOUT)
    ) u_swap (
        .clk        (clk),
        .rst        (rst),
        .start      (swap_start),
        .swap_ack   (swap_ack),
        .swap_req   (swap_req),
        .swap_count (swap_count),
        .done       (swap_done),
        .timeout    (swap_timeout)
    );

    assign mem_we       = vld_p1;
    assign mem_addr     = addr_p1;
    assign mem_data     = data_p1;
    assign mem_bank_sel = bank;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Randomized bench for weight_update_sequencer with a transaction-level
// reference model (expected write queue, sticky error flags, swap count).
module tb_weight_update_sequencer;

    localparam int NUM_WEIGHTS  = 1298;
    localparam int SWAP_TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_we, host_last;
    logic [15:0] host_addr, host_data;
    logic [1:0]  host_bank;
    logic        host_gnt;
    logic        spsa_req, spsa_we, spsa_last;
    logic [15:0] spsa_addr, spsa_data;
    logic [1:0]  temp_bank;
    logic        temp_changed;
    logic        spsa_gnt;
    logic [15:0] mem_addr, mem_data;
    logic        mem_we;
    logic [1:0]  mem_bank_sel;
    logic        swap_req, swap_ack, busy, abort_pulse;
    logic [15:0] swap_count;
    logic [2:0]  err_status;

    weight_update_sequencer dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_gnt(host_gnt), .host_addr(host_addr),
        .host_data(host_data), .host_we(host_we), .host_last(host_last),
        .host_bank(host_bank),
        .spsa_req(spsa_req), .spsa_gnt(spsa_gnt), .spsa_addr(spsa_addr),
        .spsa_data(spsa_data), .spsa_we(spsa_we), .spsa_last(spsa_last),
        .temp_bank(temp_bank), .temp_changed(temp_changed),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_bank_sel(mem_bank_sel),
        .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy),
        .swap_count(swap_count), .abort_pulse(abort_pulse),
        .err_status(err_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  bank;
        int          due;
    } wr_t;

    wr_t         exp_q[$];
    logic [2:0]  exp_err;
    logic [15:0] exp_count;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every observed memory write must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_mem_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_data", mem_data, e.data);
                chk("mem_bank_sel", mem_bank_sel, e.bank);
                chk("mem_we_latency", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        host_we = 0; host_last = 0; spsa_we = 0; spsa_last = 0; temp_changed = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_host_gnt"}, host_gnt, 0);
        chk({tag, "_spsa_gnt"}, spsa_gnt, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_mem_bank_sel"}, mem_bank_sel, 0);
        chk({tag, "_swap_req"}, swap_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_swap_count"}, swap_count, 0);
        chk({tag, "_abort_pulse"}, abort_pulse, 0);
        chk({tag, "_err_status"}, err_status, 0);
    endtask

    task automatic handshake(input int d1, input int d2);
        repeat (d1) begin
            tick();
            chk("swap_req_hold", swap_req, 1);
        end
        swap_ack = 1;
        tick();
        chk("swap_req_release", swap_req, 0);
        chk("busy_in_release", busy, 1);
        repeat (d2) tick();
        swap_ack = 0;
        tick();
        exp_count = exp_count + 16'd1;
        chk("swap_count", swap_count, exp_count);
        chk("busy_after_swap", busy, 0);
    endtask

    // mode: 0 complete with swap, 1 requester drops early, 2 temperature abort,
    // 3 complete but swap_ack never answers.
    task automatic run_burst(input bit is_host, input int nbeats, input int mode,
                             input int cut, input logic [1:0] bank, input bit seq,
                             input logic [15:0] base, input int d1);
        logic [15:0] a, d;
        if (is_host) begin host_bank = bank; host_req = 1; end
        else begin temp_bank = bank; spsa_req = 1; end
        tick();
        chk("gnt_owner", is_host ? host_gnt : spsa_gnt, 1);
        chk("gnt_other", is_host ? spsa_gnt : host_gnt, 0);
        chk("busy_in_burst", busy, 1);
        for (int i = 0; i < nbeats; i++) begin
            if (!seq && $urandom_range(0, 3) == 0) begin
                clear_beats();
                tick();
                chk("gnt_in_gap", is_host ? host_gnt : spsa_gnt, 1);
            end
            if (seq) begin
                a = base + 16'(i);
                d = 16'h1000 + 16'(i);
            end else begin
                a = ($urandom_range(0, 7) == 0) ? 16'(NUM_WEIGHTS + $urandom_range(0, 300))
                                                : 16'($urandom_range(0, NUM_WEIGHTS - 1));
                d = 16'($urandom);
            end
            if (mode == 2 && i == cut) begin
                spsa_we = 1; spsa_addr = a; spsa_data = d; spsa_last = 0; temp_changed = 1;
                tick();
                clear_beats();
                spsa_req = 0;
                chk("abort_pulse", abort_pulse, 1);
                chk("abort_gnt", spsa_gnt, 0);
                chk("abort_busy", busy, 0);
                tick();
                chk("abort_pulse_width", abort_pulse, 0);
                chk("abort_no_swap", swap_req, 0);
                return;
            end
            if (mode == 1 && i == cut) begin
                clear_beats();
                if (is_host) host_req = 0; else spsa_req = 0;
                tick();
                chk("drop_gnt", is_host ? host_gnt : spsa_gnt, 0);
                chk("drop_busy", busy, 0);
                chk("drop_no_swap", swap_req, 0);
                return;
            end
            clear_beats();
            if (is_host) begin
                host_we = 1; host_addr = a; host_data = d;
                host_last = ((mode == 0 || mode == 3) && i == nbeats - 1);
                if (!seq && $urandom_range(0, 4) == 0) temp_changed = 1;
                if (!seq && $urandom_range(0, 5) == 0) begin
                    spsa_we = 1; spsa_addr = 16'($urandom); spsa_data = 16'($urandom);
                    exp_err[2] = 1;
                end
            end else begin
                spsa_we = 1; spsa_addr = a; spsa_data = d;
                spsa_last = ((mode == 0 || mode == 3) && i == nbeats - 1);
                if (!seq && $urandom_range(0, 5) == 0) begin
                    host_we = 1; host_addr = 16'($urandom); host_data = 16'($urandom);
                    exp_err[2] = 1;
                end
            end
            if (a < 16'(NUM_WEIGHTS)) exp_q.push_back('{a, d, bank, cyc + 1});
            else exp_err[1] = 1;
            tick();
        end
        clear_beats();
        host_req = 0; spsa_req = 0;
        chk("end_gnt", is_host ? host_gnt : spsa_gnt, 0);
        chk("end_swap_req", swap_req, 1);
        chk("end_busy", busy, 1);
        if (mode == 0) begin
            handshake(d1, $urandom_range(0, 6));
        end else begin
            int n = 0;
            while (swap_req && n < SWAP_TIMEOUT + 50) begin
                tick();
                n++;
            end
            exp_err[0] = 1;
            chk("timeout_cycles", n, SWAP_TIMEOUT);
            chk("timeout_busy", busy, 0);
            chk("timeout_count", swap_count, exp_count);
            chk("timeout_err", err_status, exp_err);
        end
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        bit win_spsa;
        rst = 1;
        host_req = 0; host_addr = 0; host_data = 0; host_bank = 0;
        spsa_req = 0; spsa_addr = 0; spsa_data = 0; temp_bank = 0;
        swap_ack = 0;
        clear_beats();
        exp_err = 0; exp_count = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 0;
        tick();

        // Sequential host burst to bank 2, ack after 5 cycles.
        run_burst(1, 4, 0, 0, 2'd2, 1, 16'd0, 5);
        chk("plan_count", swap_count, 1);
        chk("plan_pending", exp_q.size(), 0);

        // SPSA burst crossing the end of the bank: 1297 written, 1298 dropped.
        run_burst(0, 2, 0, 0, 2'd1, 1, 16'd1297, 2);
        chk("range_err", err_status, exp_err);

        // SPSA abort at beat 2.
        run_burst(0, 4, 2, 2, 2'd3, 1, 16'd40, 0);
        tick();
        chk("abort_pending", exp_q.size(), 0);

        // Simultaneous requests.
        host_req = 1; spsa_req = 1; host_bank = 2'd0; temp_bank = 2'd1;
        tick();
        chk("dual_host_first", host_gnt, 1);
        chk("dual_spsa_wait", spsa_gnt, 0);
        host_we = 1; host_addr = 16'd5; host_data = 16'hBEEF; host_last = 1;
        exp_q.push_back('{16'd5, 16'hBEEF, 2'd0, cyc + 1});
        tick();
        clear_beats();
        host_req = 0;
        handshake(2, 1);
        host_req = 1;
`ifdef WUS_RR_ARB_EN
        win_spsa = 1;
`else
        win_spsa = 0;
`endif
        tick();
        chk("dual_second_host", host_gnt, !win_spsa);
        chk("dual_second_spsa", spsa_gnt, win_spsa);
        host_req = 0; spsa_req = 0;
        tick();
        chk("dual_drop_busy", busy, 0);
        chk("dual_err", err_status, exp_err);

        // Host write while SPSA owns the port.
        spsa_req = 1; temp_bank = 2'd2;
        tick();
        host_we = 1; host_addr = 16'd7; host_data = 16'h1234;
        tick();
        clear_beats();
        spsa_req = 0;
        exp_err[2] = 1;
        tick();
        chk("nogrant_err", err_status, exp_err);

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            bit is_host;
            int nb, r, mode;
            is_host = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 6);
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : (is_host ? 0 : 2);
            run_burst(is_host, nb, mode, $urandom_range(0, nb - 1), 2'($urandom),
                      0, 16'd0, $urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) tick();
            chk("rand_err", err_status, exp_err);
            chk("rand_count", swap_count, exp_count);
            chk("rand_pending", exp_q.size(), 0);
        end

        // Swap timeout with ack held low.
        run_burst(1, 2, 3, 0, 2'd1, 1, 16'd100, 0);

        // Reset while in SWAP_REQ.
        host_req = 1; host_bank = 2'd3;
        tick();
        host_we = 1; host_addr = 16'd9; host_data = 16'h0042; host_last = 1;
        exp_q.push_back('{16'd9, 16'h0042, 2'd3, cyc + 1});
        tick();
        clear_beats();
        host_req = 0;
        chk("pre_rst_swap_req", swap_req, 1);
        rst = 1;
        tick();
        exp_q.delete();
        chk_all_zero("mid_rst");
        rst = 0;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
